// File: rtl/shifter_arbiter.sv
// Two-port round-robin front end sharing one combinational 32-bit shifter.
// One registered result is held per grant until the owning port consumes it.
module shifter_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_A,
  input  logic [4:0]            req0_B,
  input  logic [1:0]            req0_op,
  output logic                  resp0_valid,
  input  logic                  resp0_ready,
  output logic [DATA_WIDTH-1:0] resp0_result,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_A,
  input  logic [4:0]            req1_B,
  input  logic [1:0]            req1_op,
  output logic                  resp1_valid,
  input  logic                  resp1_ready,
  output logic [DATA_WIDTH-1:0] resp1_result,
  output logic                  busy
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                state, state_n;
  logic                  owner, owner_n;
  logic                  rr, rr_n;
  logic [DATA_WIDTH-1:0] result_q, result_n;

  logic                  both;
  logic                  grant;
  logic                  own_ready;
  logic                  open;
  logic                  accept;
  logic [DATA_WIDTH-1:0] g_a;
  logic [4:0]            g_b;
  logic [1:0]            g_op;
  logic [DATA_WIDTH-1:0] shifted;

  // Arbitration and issue window
  always_comb begin
    both       = req0_valid & req1_valid;
    grant      = both ? rr : req1_valid;
    own_ready  = owner ? resp1_ready : resp0_ready;
    open       = ~rst & ((state == IDLE) | (state == HOLD & own_ready));
    req0_ready = open & req0_valid & ~grant;
    req1_ready = open & req1_valid & grant;
    accept     = req0_ready | req1_ready;
  end

  always_comb begin
    g_a  = grant ? req1_A  : req0_A;
    g_b  = grant ? req1_B  : req0_B;
    g_op = grant ? req1_op : req0_op;
    unique case (g_op)
      2'b00:   shifted = g_a << g_b;
      2'b10:   shifted = g_a >> g_b;
      2'b11:   shifted = $unsigned($signed(g_a) >>> g_b);
      default: shifted = '0;
    endcase
  end

  always_comb begin
    state_n  = state;
    owner_n  = owner;
    rr_n     = rr;
    result_n = result_q;
    if (accept) begin
      state_n  = HOLD;
      owner_n  = grant;
      result_n = shifted;
      if (both) rr_n = ~grant;
    end else if (state == HOLD && own_ready) begin
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      rr       <= 1'b0;
      result_q <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      rr       <= rr_n;
      result_q <= result_n;
    end
  end

  assign busy         = (state == HOLD);
  assign resp0_valid  = busy & ~owner;
  assign resp1_valid  = busy & owner;
  assign resp0_result = result_q;
  assign resp1_result = result_q;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Scoreboard bench for shifter_arbiter: expectations are queued at accept
// and checked when the owning response channel presents its result.
module tb_shifter_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, resp0_valid, resp0_ready;
  logic [31:0] req0_A, resp0_result;
  logic [4:0]  req0_B;
  logic [1:0]  req0_op;
  logic        req1_valid, req1_ready, resp1_valid, resp1_ready;
  logic [31:0] req1_A, resp1_result;
  logic [4:0]  req1_B;
  logic [1:0]  req1_op;
  logic        busy;

  typedef struct packed {
    logic        port;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  shifter_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_A(req0_A), .req0_B(req0_B), .req0_op(req0_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_result(resp0_result),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_A(req1_A), .req1_B(req1_B), .req1_op(req1_op),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_result(resp1_result),
    .busy(busy)
  );

  function automatic logic [31:0] model(input logic [31:0] a,
                                        input logic [4:0] b,
                                        input logic [1:0] op);
    logic [31:0] fill;
    fill = ~(32'hFFFF_FFFF >> b);
    case (op)
      2'b00:   return a << b;
      2'b10:   return a >> b;
      2'b11:   return (a >> b) | (a[31] ? fill : 32'h0);
      default: return 32'h0;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b0) $display("FAIL rst_req0_ready got %b want 0", req0_ready); else passes++;
    checks++; if (req1_ready !== 1'b0) $display("FAIL rst_req1_ready got %b want 0", req1_ready); else passes++;
    checks++; if ({resp1_valid, resp0_valid} !== 2'b00) $display("FAIL rst_resp_valid got %b want 00", {resp1_valid, resp0_valid}); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passes++;
    checks++; if (resp0_result !== 32'h0) $display("FAIL rst_result got %h want 0", resp0_result); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_first_ra();
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    req0_A = 32'h8000_00F0; req0_B = 5'd4; req0_op = 2'b11; req0_valid = 1'b1;
    @(negedge clk);
    checks++; if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL first_ready got %b want 01", {req1_ready, req0_ready}); else passes++;
    sb.push_back('{port: 1'b0, res: 32'hF800_000F});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    checks++; if ({resp1_valid, resp0_valid} !== 2'b01) $display("FAIL first_valid got %b want 01", {resp1_valid, resp0_valid}); else passes++;
    checks++;
    if (sb.size() == 0) $display("FAIL first_sb queue empty got 0 want 1");
    else begin
      e = sb.pop_front();
      if (resp0_result !== e.res) $display("FAIL first_result got %h want %h", resp0_result, e.res); else passes++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_ops();
    logic [31:0] ta [4] = '{32'h8000_00F0, 32'h1, 32'hDEAD_BEEF, 32'h1234_5678};
    logic [4:0]  tb [4] = '{5'd4, 5'd31, 5'd7, 5'd0};
    logic [1:0]  to [4] = '{2'b10, 2'b00, 2'b01, 2'b11};
    logic [31:0] tx [4] = '{32'h0800_000F, 32'h8000_0000, 32'h0, 32'h1234_5678};
    for (int i = 0; i < 4; i++) begin
      req1_A = ta[i]; req1_B = tb[i]; req1_op = to[i]; req1_valid = 1'b1;
      @(negedge clk);
      checks++; if ({req1_ready, req0_ready} !== 2'b10) $display("FAIL single%0d_ready got %b want 10", i, {req1_ready, req0_ready}); else passes++;
      sb.push_back('{port: 1'b1, res: tx[i]});
      @(posedge clk); #1;
      req1_valid = 1'b0;
      @(negedge clk);
      checks++; if ({resp1_valid, resp0_valid} !== 2'b10) $display("FAIL single%0d_valid got %b want 10", i, {resp1_valid, resp0_valid}); else passes++;
      checks++;
      if (sb.size() == 0) $display("FAIL single%0d_sb queue empty got 0 want 1", i);
      else begin
        e = sb.pop_front();
        if (resp1_result !== e.res) $display("FAIL single%0d_result got %h want %h", i, resp1_result, e.res); else passes++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic g;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    req0_A = $urandom; req0_B = 5'($urandom_range(31, 0)); req0_op = 2'($urandom_range(3, 0));
    req1_A = $urandom; req1_B = 5'($urandom_range(31, 0)); req1_op = 2'($urandom_range(3, 0));
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      g = 1'(i % 2);
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (sb.size() == 0 || !(resp0_valid | resp1_valid))
          $display("FAIL b2b%0d_resp missing got %b want one", i, {resp1_valid, resp0_valid});
        else begin
          e = sb.pop_front();
          if ({resp1_valid, resp0_valid} !== (e.port ? 2'b10 : 2'b01) || resp0_result !== e.res)
            $display("FAIL b2b%0d_resp got %b/%h want port %0d/%h", i, {resp1_valid, resp0_valid}, resp0_result, e.port, e.res);
          else passes++;
        end
      end
      checks++; if ({req1_ready, req0_ready} !== (g ? 2'b10 : 2'b01)) $display("FAIL b2b%0d_grant got %b want port %0d", i, {req1_ready, req0_ready}, g); else passes++;
      if (g) sb.push_back('{port: 1'b1, res: model(req1_A, req1_B, req1_op)});
      else   sb.push_back('{port: 1'b0, res: model(req0_A, req0_B, req0_op)});
      @(posedge clk); #1;
      if (g) begin
        req1_A = $urandom; req1_B = 5'($urandom_range(31, 0)); req1_op = 2'($urandom_range(3, 0));
      end else begin
        req0_A = $urandom; req0_B = 5'($urandom_range(31, 0)); req0_op = 2'($urandom_range(3, 0));
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (sb.size() == 0) $display("FAIL b2b_last_sb queue empty got 0 want 1");
    else begin
      e = sb.pop_front();
      if ({resp1_valid, resp0_valid} !== (e.port ? 2'b10 : 2'b01) || resp0_result !== e.res)
        $display("FAIL b2b_last_resp got %b/%h want port %0d/%h", {resp1_valid, resp0_valid}, resp0_result, e.port, e.res);
      else passes++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    rst = 1'b1; #1; rst = 1'b0;
    sb.delete();
    req0_A = 32'hF000_000F; req0_B = 5'd8;  req0_op = 2'b11;
    req1_A = 32'h0000_ABCD; req1_B = 5'd12; req1_op = 2'b00;
    resp0_ready = 1'b0; resp1_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    checks++; if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL stall_grant got %b want 01", {req1_ready, req0_ready}); else passes++;
    sb.push_back('{port: 1'b0, res: 32'hFFF0_0000});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({req1_ready, req0_ready} !== 2'b00 || busy !== 1'b1 || resp0_valid !== 1'b1 || resp0_result !== sb[0].res)
        $display("FAIL stall%0d got rdy=%b busy=%b v0=%b res=%h want 00/1/1/%h", k, {req1_ready, req0_ready}, busy, resp0_valid, resp0_result, sb[0].res);
      else passes++;
    end
    @(posedge clk); #1;
    resp0_ready = 1'b1;
    @(negedge clk);
    checks++; if ({req1_ready, req0_ready} !== 2'b10) $display("FAIL stall_release_grant got %b want 10", {req1_ready, req0_ready}); else passes++;
    e = sb.pop_front();
    checks++; if (resp0_valid !== 1'b1 || resp0_result !== e.res) $display("FAIL stall_release_resp got %b/%h want 1/%h", resp0_valid, resp0_result, e.res); else passes++;
    sb.push_back('{port: 1'b1, res: 32'h0ABC_D000});
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    checks++; if ({resp1_valid, resp0_valid} !== 2'b10 || resp1_result !== e.res) $display("FAIL stall_resp1 got %b/%h want 10/%h", {resp1_valid, resp0_valid}, resp1_result, e.res); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    // rr is 1 here; first contended grant goes to port 1, the next to 0 leaving rr=1
    resp0_ready = 1'b0; resp1_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    checks++; if ({req1_ready, req0_ready} !== 2'b10) $display("FAIL ar_grant1 got %b want 10", {req1_ready, req0_ready}); else passes++;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL ar_grant0 got %b want 01", {req1_ready, req0_ready}); else passes++;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (resp0_valid !== 1'b1 || busy !== 1'b1 || {req1_ready, req0_ready} !== 2'b00) $display("FAIL ar_hold got v0=%b busy=%b rdy=%b want 1/1/00", resp0_valid, busy, {req1_ready, req0_ready}); else passes++;
    #1 rst = 1'b1;
    #1;
    checks++; if (resp0_valid !== 1'b0 || busy !== 1'b0 || {req1_ready, req0_ready} !== 2'b00) $display("FAIL ar_drop got v0=%b busy=%b rdy=%b want 0/0/00", resp0_valid, busy, {req1_ready, req0_ready}); else passes++;
    sb.delete();
    rst = 1'b0;
    resp0_ready = 1'b1;
    req0_A = 32'h0000_00FF; req0_B = 5'd4; req0_op = 2'b00;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL ar_rr_reset got %b want 01", {req1_ready, req0_ready}); else passes++;
    sb.push_back('{port: 1'b0, res: 32'h0000_0FF0});
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (resp0_valid !== 1'b1 || resp0_result !== e.res) $display("FAIL ar_after_resp got %b/%h want 1/%h", resp0_valid, resp0_result, e.res); else passes++;
    @(posedge clk); #1;
    checks++; if (sb.size() != 0) $display("FAIL sb_drain got %0d want 0", sb.size()); else passes++;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_A = '0; req0_B = '0; req0_op = '0; resp0_ready = 1'b0;
    req1_valid = 1'b0; req1_A = '0; req1_B = '0; req1_op = '0; resp1_ready = 1'b0;
    test_reset();
    test_first_ra();
    test_single_ops();
    test_back_to_back();
    test_stall();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/shifter_arbiter.md
Name: shifter_arbiter

Overview:
- Shares one combinational 32-bit shifter datapath between two requesters with valid/ready handshakes (port 0: ALU execute path, port 1: load/store byte-alignment path).
- Round-robin arbitration on the request side; a registered result is returned on the winning requester's response channel.
- Single outstanding operation; back-to-back issue is allowed when the response is consumed in the same cycle.

Parameters:
- DATA_WIDTH, 32, operand/result width; shift amount is fixed at 5 bits.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle when valid&ready
- req0_A  input  DATA_WIDTH  operand, treated as signed for arithmetic shift
- req0_B  input  5  shift amount
- req0_op  input  2  Shiftop: 00 LL, 10 RL, 11 RA, 01 reserved
- resp0_valid  output  1  result for requester 0 available
- resp0_ready  input  1  requester 0 consumes result
- resp0_result  output  DATA_WIDTH  shift result for requester 0
- req1_valid, req1_ready, req1_A, req1_B, req1_op  (same as port 0, requester 1)
- resp1_valid, resp1_ready, resp1_result  (same as port 0, requester 1)
- busy  output  1  a result is held and not yet consumed

Behaviour:
- State: IDLE, HOLD. Registers: state, owner (1 bit), rr pointer (1 bit, favoured port), result_q.
- Reset (async, any time): state=IDLE, owner=0, rr=0, result_q=0. All resp*_valid=0, busy=0, req*_ready=0. Any held result is discarded; an operation accepted in the reset cycle is lost.
- Issue window: open = (state==IDLE) | (state==HOLD & resp_owner_valid & resp_owner_ready).
- Grant (combinational):
  - Both valid: grant rr.
  - One valid: grant that port.
  - None valid: no grant.
- reqN_ready = open & grant==N. At most one req*_ready is high per cycle. reqN_ready never asserts for a non-granted port, even if that port is valid.
- Accept (valid&ready on granted port N), at the next edge:
  - result_q = shift(A_N, B_N, op_N)
  - owner = N
  - state = HOLD
  - rr = ~N, only when both ports were valid. rr is unchanged on an uncontested grant.
- Shift function:
  - LL: A<<B.
  - RL: logical right, zero fill.
  - RA: arithmetic right, sign fill from A[31].
  - 01: result 0.
  - B=0 returns A unchanged.
- Latency: 1 cycle. resp_owner_valid rises the cycle after acceptance.
- In HOLD:
  - resp_owner_valid=1. The other port's resp_valid=0.
  - resp*_result always drives result_q on both ports; consumers qualify with valid.
  - result_q and owner are stable until consumed. busy=1.
- Response handshake:
  - resp_owner_ready=1 in HOLD with no new accept in the same cycle: state goes to IDLE next cycle.
  - With a simultaneous accept: state stays HOLD, and owner/result_q load the new operation (possibly the other port). Sustained throughput is one operation per cycle.
- resp*_ready while that port's resp_valid=0 is ignored.
- Request inputs must be held stable while valid and not ready. The arbiter samples them only on the accept edge.
- Fairness: under continuous contention grants alternate 0,1,0,1... Neither port waits more than one grant of the other.

Test Plan:
- Reset, then req0 valid with A=0x8000_00F0, B=4, op=11 → req0_ready=1 that cycle; next cycle resp0_valid=1, resp0_result=0xF800_000F, resp1_valid=0.
- Single-op results, each observed on resp1:
  - req1 A=0x8000_00F0, B=4, op=10 → 0x0800_000F
  - op=00, B=31, A=1 → 0x8000_0000
  - op=01 → 0x0000_0000
  - B=0 → A unchanged
- Both ports valid every cycle, resp ready held at 1 → grants alternate 0,1,0,1 starting with 0; one result per cycle, each on the correct port.
- Contention after reset, then resp0_ready=0 for 3 cycles → req*_ready=0, busy=1, resp0_result held constant; when resp0_ready=1, req1 is accepted the same cycle and resp1_valid=1 on the next cycle.
- Assert rst asynchronously mid-HOLD (between edges) → resp0_valid, busy and ready drop immediately; after release the first contended grant goes to port 0 (rr=0).
